fixed_predictor_decoder: RTL
============================

Name: fixed_predictor_decoder

Overview:
- Parametrised FLAC fixed-predictor subframe decoder.
- Supports all fixed orders 0..MAX_ORDER, selected per subframe.
- Takes one residual per enabled cycle and emits one reconstructed sample, with fixed latency.
- Sits between the residual (Rice) decoder and the channel decorrelation stage; replaces the single-order, 16-bit, order-3-only decoder.

Parameters:
- DATA_W, 16: sample/residual width (signed, two's complement).
- MAX_ORDER, 4: highest supported predictor order (1..4).

Ports:
- iClock  in  1  clock; all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  start of a new subframe; latches iOrder and clears history/warmup.
- iOrder  in  3  predictor order for the subframe; sampled only when iStart=1.
- iEnable  in  1  iSample valid this cycle.
- iSample  in  DATA_W  signed warmup sample or residual.
- oData  out  DATA_W  signed reconstructed sample.
- oValid  out  1  oData valid this cycle.
- oOverflow  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (iReset=1): all registers cleared. oData=0, oValid=0, oOverflow=0, history h1..h4=0, order=0, warmup count=0.
- Reset mid-subframe: in-flight samples are discarded. No oValid is produced for them.
- Order latch:
  - On iStart=1, order <= iOrder, clamped to MAX_ORDER if iOrder > MAX_ORDER.
  - On iStart=1, warmup count <= 0 and h1..h4 <= 0.
  - If iEnable=1 in the same cycle, that sample is warmup sample 0 of the new subframe, using the new order.
- Warmup:
  - While warmup count < order, an enabled sample is passed through verbatim.
  - Each such sample increments the warmup count; the count saturates at order.
- Prediction, once count = order. h1 is the newest sample.
  - order 0: 0
  - order 1: h1
  - order 2: 2h1 - h2
  - order 3: 3h1 - 3h2 + h3
  - order 4: 4h1 - 6h2 + 4h3 - h4
- Reconstruction:
  - recon = iSample + prediction, computed at DATA_W+4 bits signed with no intermediate overflow.
  - Reduced to DATA_W bits (wrap, or saturate with the macro).
  - The reduced value shifts into history: h4<=h3, h3<=h2, h2<=h1, h1<=recon.
- Single-cycle recurrence: the predictor is combinational from the history registers, so one sample per cycle is sustainable (iEnable=1 every cycle).
- Pipeline:
  - Stage 1 registers recon into h1 plus a valid bit.
  - Stage 2 registers oData/oValid.
  - Latency: a sample accepted at edge N appears at oData with oValid=1 after edge N+2.
- The pipeline advances every cycle regardless of iEnable.
- iEnable=0: history is held and a bubble propagates, giving oValid=0 two cycles later. oData holds its last value.
- Gaps of any length inside a subframe are allowed and do not disturb the history.
- iStart during flight: samples already accepted still emit normally. Only history and order change.

Optional Feature:
- Macro: FIXED_PREDICTOR_SAT_EN.
- Defined:
  - recon outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] is clamped to the nearest bound.
  - oOverflow goes high together with the offending oValid.
  - oOverflow stays high until iReset or iStart.
- Undefined:
  - recon wraps (low DATA_W bits kept).
  - oOverflow is tied to 0.

Test Plan:
1. Order 0: iStart with iOrder=0, residuals 5, -3, 7 on consecutive cycles -> oData 5, -3, 7 with oValid, first output 2 cycles after the first accept.
2. Order 2: warmup 10, 20 then residuals 0, 0, 1 -> outputs 10, 20, 30, 40, 51.
3. Order 3 and order 4:
   - Order 3: warmup 1, 4, 9 then residuals 0, 0 -> outputs 1, 4, 9, 16, 25.
   - Order 4: warmup 1, 8, 27, 64 then residual 0 -> output 125.
4. Gaps, clamp and restart:
   - Order 2 stream with iEnable deasserted 3 cycles between samples -> identical values, oValid bubbles matching the gaps.
   - iOrder=7 -> behaves as order 4.
   - iStart mid-stream with order 1: warmup 100, residual -1 -> output 99.
5. Reset mid-subframe: iReset asserted while 2 samples are in flight -> no oValid for them, oData=0; a new subframe after reset decodes correctly.
6. Overflow: DATA_W=16, order 1, warmup 32767, residual 1 -> oData -32768 (no macro) or 32767 with oOverflow=1 and sticky (FIXED_PREDICTOR_SAT_EN).

Source files
------------

// File: rtl/fixed_predictor_decoder.sv
// FLAC fixed-predictor subframe decoder, orders 0..MAX_ORDER, one sample per cycle, 2-cycle latency.
// Optional saturation and sticky overflow flag: define FIXED_PREDICTOR_SAT_EN.
module fixed_predictor_decoder #(
   parameter int DATA_W    = 16,
   parameter int MAX_ORDER = 4
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iStart,
   input  logic [2:0]               iOrder,
   input  logic                     iEnable,
   input  logic signed [DATA_W-1:0] iSample,
   output logic signed [DATA_W-1:0] oData,
   output logic                     oValid,
   output logic                     oOverflow
);

   localparam int EW = DATA_W + 4;
   localparam logic [2:0] MAX_ORD = 3'(MAX_ORDER);

   typedef logic signed [EW-1:0] ext_t;

   logic [2:0]               order;
   logic [2:0]               wcnt;
   logic signed [DATA_W-1:0] h1, h2, h3, h4;
   logic                     s1_valid;

   logic [2:0]               sel_order;
   logic [2:0]               sel_cnt;
   logic signed [DATA_W-1:0] hs1, hs2, hs3, hs4;
   ext_t                     e1, e2, e3, e4;
   ext_t                     pred;
   ext_t                     recon_ext;
   logic                     warm;
   logic signed [DATA_W-1:0] recon;

`ifdef FIXED_PREDICTOR_SAT_EN
   localparam ext_t HI = ext_t'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam ext_t LO = ext_t'(-(64'sd1 <<< (DATA_W - 1)));
   logic ovf;
   logic s1_ovf;
   logic ovf_flag;
`endif

   // A start in the same cycle as a sample makes that sample use the new order and cleared history.
   always_comb begin
      sel_order = iStart ? ((iOrder > MAX_ORD) ? MAX_ORD : iOrder) : order;
      sel_cnt   = iStart ? '0 : wcnt;
      hs1       = iStart ? '0 : h1;
      hs2       = iStart ? '0 : h2;
      hs3       = iStart ? '0 : h3;
      hs4       = iStart ? '0 : h4;
      e1        = ext_t'(hs1);
      e2        = ext_t'(hs2);
      e3        = ext_t'(hs3);
      e4        = ext_t'(hs4);
      case (sel_order)
         3'd1:    pred = e1;
         3'd2:    pred = (e1 <<< 1) - e2;
         3'd3:    pred = (e1 <<< 1) + e1 - (e2 <<< 1) - e2 + e3;
         3'd4:    pred = (e1 <<< 2) - (e2 <<< 2) - (e2 <<< 1) + (e3 <<< 2) - e4;
         default: pred = '0;
      endcase
      warm      = sel_cnt < sel_order;
      recon_ext = warm ? ext_t'(iSample) : ext_t'(iSample) + pred;
`ifdef FIXED_PREDICTOR_SAT_EN
      ovf   = 1'b0;
      recon = DATA_W'(recon_ext);
      if (recon_ext > HI) begin
         ovf   = 1'b1;
         recon = DATA_W'(HI);
      end else if (recon_ext < LO) begin
         ovf   = 1'b1;
         recon = DATA_W'(LO);
      end
`else
      recon = DATA_W'(recon_ext);
`endif
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         order    <= '0;
         wcnt     <= '0;
         h1       <= '0;
         h2       <= '0;
         h3       <= '0;
         h4       <= '0;
         s1_valid <= 1'b0;
         oData    <= '0;
         oValid   <= 1'b0;
      end else begin
         if (iStart) begin
            order <= sel_order;
            wcnt  <= '0;
            h1    <= '0;
            h2    <= '0;
            h3    <= '0;
            h4    <= '0;
         end
         if (iEnable) begin
            h4   <= hs3;
            h3   <= hs2;
            h2   <= hs1;
            h1   <= recon;
            wcnt <= warm ? sel_cnt + 3'd1 : sel_cnt;
         end
         s1_valid <= iEnable;
         // h1 still holds the in-flight sample here even if a start clears it at this edge.
         oValid   <= s1_valid;
         if (s1_valid)
            oData <= h1;
      end
   end

`ifdef FIXED_PREDICTOR_SAT_EN
   always_ff @(posedge iClock) begin
      if (iReset) begin
         s1_ovf   <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         s1_ovf <= iEnable & ovf;
         if (s1_valid && s1_ovf)
            ovf_flag <= 1'b1;
         else if (iStart)
            ovf_flag <= 1'b0;
      end
   end
   assign oOverflow = ovf_flag;
`else
   assign oOverflow = 1'b0;
`endif

endmodule
